mac_result_sink: RTL

Hardware capture endpoint for the signed 16-bit result stream `f` produced by `mac`. It buffers accepted samples in a small synchronous FIFO and keeps running statistics (sample count, min, max, drop count, sticky overflow). It exposes a valid/ready drain port so a host, or a bench-side checker, can read the results in order. It sits directly downstream of `mac`, which has no backpressure, and replaces per-cycle file logging with an on-chip record.

---
 rtl/mac_pkg.sv | 15 +
 rtl/sink_fifo.sv | 92 +++++++++
 rtl/mac_result_sink.sv | 95 +++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types for the mac datapath and its result sink.
package mac_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 32;

    typedef logic signed [DATA_W-1:0] mac_result_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/sink_fifo.sv
// Synchronous register FIFO with a registered head; push into a full FIFO
// is allowed only when a pop happens in the same cycle.
module sink_fifo
    import mac_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_push_req,
    input  logic                     i_pop_req,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_push_acc
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    fifo_state_t      r_state;
    fifo_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [LW-1:0]    w_level_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_pop       = (r_state != ST_EMPTY) && i_pop_req;
    assign w_push      = i_push_req && ((r_state != ST_FULL) || w_pop);
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_clr) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY:   if (w_push) w_state_nxt = ST_PARTIAL;
                ST_PARTIAL: begin
                    if (w_level_nxt == LW'(DEPTH)) w_state_nxt = ST_FULL;
                    else if (w_level_nxt == '0)    w_state_nxt = ST_EMPTY;
                end
                ST_FULL:    if (w_pop && !w_push) w_state_nxt = ST_PARTIAL;
                default:    w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_clr) r_mem[r_rd_ptr == r_wr_ptr ? r_wr_ptr : r_wr_ptr] <= i_wdata;
    end

    // Storage is not reset, so the head is forced to zero whenever nothing is held.
    assign o_valid    = (r_state != ST_EMPTY);
    assign o_full     = (r_state == ST_FULL);
    assign o_rdata    = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level    = r_level;
    assign o_push_acc = w_push;

endmodule

// File: rtl/mac_result_sink.sv
// Capture endpoint for the mac result stream: buffers accepted samples and
// keeps count/min/max/drop statistics with a valid/ready drain port.
module mac_result_sink #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = mac_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     stats_valid,
    output logic signed [DATA_W-1:0] min_val,
    output logic signed [DATA_W-1:0] max_val
);

    logic                     w_push_acc;
    logic                     w_drop;
    logic [CNT_W-1:0]         r_sample_cnt;
    logic [CNT_W-1:0]         r_drop_cnt;
    logic                     r_overflow;
    logic                     r_stats_valid;
    logic signed [DATA_W-1:0] r_min;
    logic signed [DATA_W-1:0] r_max;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    sink_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_clr      (clear),
        .i_push_req (in_valid),
        .i_pop_req  (out_ready),
        .i_wdata    (in_data),
        .o_rdata    (out_data),
        .o_valid    (out_valid),
        .o_level    (level),
        .o_full     (full),
        .o_push_acc (w_push_acc)
    );

    assign w_drop = in_valid && !w_push_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample_cnt  <= '0;
            r_drop_cnt    <= '0;
            r_overflow    <= 1'b0;
            r_stats_valid <= 1'b0;
            r_min         <= '0;
            r_max         <= '0;
        end else if (clear) begin
            r_sample_cnt  <= '0;
            r_drop_cnt    <= '0;
            r_overflow    <= 1'b0;
            r_stats_valid <= 1'b0;
            r_min         <= '0;
            r_max         <= '0;
        end else begin
            // The first accepted sample seeds both extremes.
            if (w_push_acc) begin
                r_sample_cnt  <= r_sample_cnt + CNT_W'(1);
                r_stats_valid <= 1'b1;
                if (!r_stats_valid || (in_data < r_min)) r_min <= in_data;
                if (!r_stats_valid || (in_data > r_max)) r_max <= in_data;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    assign sample_cnt  = r_sample_cnt;
    assign drop_cnt    = r_drop_cnt;
    assign overflow    = r_overflow;
    assign stats_valid = r_stats_valid;
    assign min_val     = r_min;
    assign max_val     = r_max;

endmodule
